// File: rtl/fifo_uart_tx.sv
// Pops one word from a first-word-fall-through FIFO whenever the line is idle, sends it LSB first as an 8N1 frame.
// Timing uses 16x oversampling with tick period dvsr+1 clocks; pop lands in the same cycle IDLE sees a non-empty FIFO.
module fifo_uart_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int SB_TICK    = 16,
  parameter int DVSR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DVSR_WIDTH-1:0] dvsr,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_r_data,
  output logic                  fifo_rd,
  output logic                  tx,
  output logic                  tx_busy
);

  localparam int S_W = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int N_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_t;

  state_t                state_q, state_d;
  logic [DVSR_WIDTH-1:0] baud_q, baud_d;
  logic [S_W-1:0]        s_q, s_d;
  logic [N_W-1:0]        n_q, n_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  tick;

  assign tick    = (baud_q == dvsr);
  assign fifo_rd = (state_q == IDLE) & ~fifo_empty & ~reset;
  assign tx      = tx_q;
  assign tx_busy = busy_q;

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    shift_d = shift_q;
    baud_d  = (state_q == IDLE || tick) ? '0 : baud_q + DVSR_WIDTH'(1);
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          shift_d = fifo_r_data;
          s_d     = '0;
          state_d = START;
        end
      end
      START: begin
        if (tick) begin
          if (s_q == S_W'(15)) begin
            s_d     = '0;
            n_d     = '0;
            state_d = DATA;
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (s_q == S_W'(15)) begin
            s_d     = '0;
            shift_d = shift_q >> 1;
            if (n_q == N_W'(DATA_WIDTH - 1)) state_d = STOP;
            else                             n_d = n_q + N_W'(1);
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (s_q == S_W'(SB_TICK - 1)) state_d = IDLE;
          else                          s_d = s_q + S_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level follows the next state so tx switches on the same edge as the FSM.
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      s_q     <= '0;
      n_q     <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      s_q     <= s_d;
      n_q     <= n_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Randomised and directed checks of fifo_uart_tx against a frame-arithmetic reference model and a queue FIFO.
module tb_fifo_uart_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] dvsr;
  logic        fifo_empty;
  logic [7:0]  fifo_r_data;
  logic        fifo_rd, tx, tx_busy;
  logic        empty2;
  logic [7:0]  data2;
  logic        rd2, tx2, busy2;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] fq[$];
  int         pop_t[$];
  logic [7:0] pop_b[$];
  int         pop_cnt = 0;
  bit         pop_req = 0;
  bit         mon_en  = 0;

  bit         f_act = 0;
  int         f_t = 0, f_dv = 0, m_k, m_len;
  logic [7:0] f_byte = 8'h00;
  logic       e_tx, e_busy, e_rd;
  logic [7:0] dropped;

  fifo_uart_tx #(.DATA_WIDTH(8), .SB_TICK(16), .DVSR_WIDTH(11)) dut (
    .clk(clk), .reset(reset), .dvsr(dvsr), .fifo_empty(fifo_empty), .fifo_r_data(fifo_r_data),
    .fifo_rd(fifo_rd), .tx(tx), .tx_busy(tx_busy));

  fifo_uart_tx #(.DATA_WIDTH(8), .SB_TICK(32), .DVSR_WIDTH(11)) dut2 (
    .clk(clk), .reset(reset), .dvsr(dvsr), .fifo_empty(empty2), .fifo_r_data(data2),
    .fifo_rd(rd2), .tx(tx2), .tx_busy(busy2));

  always #5 clk = ~clk;

  // Expected line level at offset k (>=0) from the first start-bit cycle, from frame layout alone.
  function automatic logic exp_bit(input int k, input logic [7:0] b, input int dv);
    int idx;
    idx = k / (16 * (dv + 1));
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    return 1'b1;
  endfunction

  task automatic sync_fifo();
    fifo_empty  = (fq.size() == 0);
    fifo_r_data = (fq.size() != 0) ? fq[0] : 8'h00;
  endtask

  task automatic push(input logic [7:0] b);
    fq.push_back(b);
    sync_fifo();
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic goto(input int c);
    while (cyc < c) step();
  endtask

  task automatic wait_pop(input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (pop_cnt >= target) begin ok = 1'b1; break; end
      step();
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (fq.size() == 0 && !pop_req && tx_busy === 1'b0 && busy2 === 1'b0) begin ok = 1'b1; break; end
      step();
    end
  endtask

  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (pop_req) begin
      dropped = fq.pop_front();
      pop_req = 1'b0;
      sync_fifo();
    end
  end

  // Reference model: one frame at a time, timed purely from the pop cycle and the frame length.
  always @(negedge clk) begin
    if (mon_en) begin
      m_k   = cyc - (f_t + 1);
      m_len = 160 * (f_dv + 1);
      if (f_act && m_k >= m_len) f_act = 0;
      e_busy = f_act && (m_k >= 0);
      e_tx   = e_busy ? exp_bit(m_k, f_byte, f_dv) : 1'b1;
      e_rd   = !reset && !e_busy && (fq.size() != 0);
      total += 3;
      if (tx !== e_tx) begin bad++; $display("FAIL mon_tx cyc=%0d got=%b exp=%b", cyc, tx, e_tx); end
      if (tx_busy !== e_busy) begin bad++; $display("FAIL mon_busy cyc=%0d got=%b exp=%b", cyc, tx_busy, e_busy); end
      if (fifo_rd !== e_rd) begin bad++; $display("FAIL mon_rd cyc=%0d got=%b exp=%b", cyc, fifo_rd, e_rd); end
      if (reset) f_act = 0;
      else if (fifo_rd === 1'b1 && fq.size() != 0) begin
        f_act = 1; f_t = cyc; f_byte = fq[0]; f_dv = int'(dvsr);
        pop_req = 1'b1; pop_cnt++;
        pop_t.push_back(cyc); pop_b.push_back(fq[0]);
      end
    end
  end

  task automatic test_reset();
    bit ok;
    push(8'hC3);
    @(posedge clk); #2;
    mon_en = 1;
    for (int i = 0; i < 3; i++) begin
      total += 3;
      if (fifo_rd !== 1'b0) begin bad++; $display("FAIL rst_rd got=%b exp=0", fifo_rd); end
      if (tx !== 1'b1) begin bad++; $display("FAIL rst_tx got=%b exp=1", tx); end
      if (tx_busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", tx_busy); end
      if (i < 2) step();
    end
    reset = 1'b0;
    #1;
    total++;
    if (fifo_rd !== 1'b1) begin bad++; $display("FAIL rst_first_pop got=%b exp=1", fifo_rd); end
    wait_idle(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL rst_idle timeout got=0 exp=1"); end
  endtask

  task automatic test_single();
    bit ok; int p0, t;
    logic [9:0] bits;
    bits = 10'b1101001010;
    dvsr = 11'd1; p0 = pop_cnt;
    push(8'hA5);
    wait_pop(p0 + 1, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL single_pop timeout got=0 exp=1"); end
    else begin
      t = pop_t[p0];
      for (int i = 0; i < 10; i++) begin
        goto(t + 1 + i * 32 + 16);
        total++;
        if (tx !== bits[i]) begin bad++; $display("FAIL single_bit%0d got=%b exp=%b", i, tx, bits[i]); end
      end
      goto(t + 320);
      total++;
      if (tx_busy !== 1'b1) begin bad++; $display("FAIL single_busy_end got=%b exp=1", tx_busy); end
      goto(t + 321);
      total += 2;
      if (tx_busy !== 1'b0) begin bad++; $display("FAIL single_busy_fall got=%b exp=0", tx_busy); end
      if (pop_cnt !== p0 + 1) begin bad++; $display("FAIL single_pops got=%0d exp=%0d", pop_cnt, p0 + 1); end
    end
  endtask

  task automatic test_back_to_back();
    bit ok; int p0, t1;
    dvsr = 11'd0; p0 = pop_cnt;
    push(8'h00); push(8'hFF);
    wait_pop(p0 + 1, ok);
    if (ok) begin
      t1 = pop_t[p0];
      goto(t1 + 161);
      total += 2;
      if (tx !== 1'b1) begin bad++; $display("FAIL b2b_gap_tx got=%b exp=1", tx); end
      if (fifo_rd !== 1'b1) begin bad++; $display("FAIL b2b_gap_rd got=%b exp=1", fifo_rd); end
      goto(t1 + 162);
      total++;
      if (tx !== 1'b0) begin bad++; $display("FAIL b2b_start2 got=%b exp=0", tx); end
    end
    wait_pop(p0 + 2, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL b2b_pop timeout got=0 exp=1"); end
    else begin
      total++;
      if (pop_t[p0+1] - pop_t[p0] != 161) begin
        bad++; $display("FAIL b2b_spacing got=%0d exp=161", pop_t[p0+1] - pop_t[p0]);
      end
    end
    wait_idle(ok);
    repeat (20) step();
    total += 3;
    if (pop_cnt !== p0 + 2) begin bad++; $display("FAIL b2b_pops got=%0d exp=%0d", pop_cnt, p0 + 2); end
    if (tx !== 1'b1) begin bad++; $display("FAIL b2b_idle_tx got=%b exp=1", tx); end
    if (fifo_empty !== 1'b1) begin bad++; $display("FAIL b2b_empty got=%b exp=1", fifo_empty); end
  endtask

  task automatic test_two_stop();
    int t; logic etx; bit ebusy;
    dvsr = 11'd2;
    empty2 = 1'b0; data2 = 8'h3C;
    #1;
    total++;
    if (rd2 !== 1'b1) begin bad++; $display("FAIL sb2_pop got=%b exp=1", rd2); end
    t = cyc;
    step();
    empty2 = 1'b1;
    for (int k = 0; k < 534; k++) begin
      goto(t + 1 + k);
      ebusy = (k < 528);
      etx = ebusy ? exp_bit(k, 8'h3C, 2) : 1'b1;
      total += 3;
      if (tx2 !== etx) begin bad++; $display("FAIL sb2_tx k=%0d got=%b exp=%b", k, tx2, etx); end
      if (busy2 !== ebusy) begin bad++; $display("FAIL sb2_busy k=%0d got=%b exp=%b", k, busy2, ebusy); end
      if (rd2 !== 1'b0) begin bad++; $display("FAIL sb2_rd k=%0d got=%b exp=0", k, rd2); end
    end
  endtask

  task automatic test_reset_mid();
    bit ok; int p0, t;
    dvsr = 11'd0; p0 = pop_cnt;
    push(8'h55); push(8'h96);
    wait_pop(p0 + 1, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL rmid_pop timeout got=0 exp=1"); end
    else begin
      t = pop_t[p0];
      goto(t + 1 + 4 * 16 + 8);
      reset = 1'b1;
      step();
      total += 2;
      if (tx !== 1'b1) begin bad++; $display("FAIL rmid_tx got=%b exp=1", tx); end
      if (tx_busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b exp=0", tx_busy); end
      for (int i = 0; i < 3; i++) begin
        total++;
        if (fifo_rd !== 1'b0) begin bad++; $display("FAIL rmid_rd_hold got=%b exp=0", fifo_rd); end
        step();
      end
      reset = 1'b0;
      #1;
      total++;
      if (fifo_rd !== 1'b1) begin bad++; $display("FAIL rmid_repop got=%b exp=1", fifo_rd); end
    end
    wait_idle(ok);
    total++;
    if (pop_cnt !== p0 + 2) begin bad++; $display("FAIL rmid_pops got=%0d exp=%0d", pop_cnt, p0 + 2); end
    else begin
      total++;
      if (pop_b[p0+1] !== 8'h96) begin bad++; $display("FAIL rmid_byte got=%h exp=96", pop_b[p0+1]); end
    end
  endtask

  task automatic test_empty_stall();
    bit ok; int p0, e;
    dvsr = 11'd0; p0 = pop_cnt;
    push(8'($urandom));
    wait_pop(p0 + 1, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL stall_pop timeout got=0 exp=1"); end
    else begin
      e = pop_t[p0] + 161;
      goto(e);
      total += 3;
      if (tx !== 1'b1) begin bad++; $display("FAIL stall_tx got=%b exp=1", tx); end
      if (tx_busy !== 1'b0) begin bad++; $display("FAIL stall_busy got=%b exp=0", tx_busy); end
      if (fifo_rd !== 1'b0) begin bad++; $display("FAIL stall_rd got=%b exp=0", fifo_rd); end
      goto(e + 49);
      total++;
      if (pop_cnt !== p0 + 1) begin bad++; $display("FAIL stall_nopop got=%0d exp=%0d", pop_cnt, p0 + 1); end
      goto(e + 50);
      push(8'($urandom));
      #1;
      total++;
      if (fifo_rd !== 1'b1) begin bad++; $display("FAIL stall_resume got=%b exp=1", fifo_rd); end
    end
    wait_idle(ok);
  endtask

  task automatic test_random();
    bit ok; int p0, n;
    logic [7:0] sent[$];
    for (int r = 0; r < 4; r++) begin
      dvsr = 11'($urandom_range(0, 3));
      n = $urandom_range(1, 3);
      p0 = pop_cnt;
      sent.delete();
      for (int i = 0; i < n; i++) begin
        sent.push_back(8'($urandom));
        push(sent[i]);
      end
      wait_idle(ok);
      total++;
      if (!ok || pop_cnt !== p0 + n) begin
        bad++; $display("FAIL rand_pops r=%0d got=%0d exp=%0d", r, pop_cnt - p0, n);
      end else begin
        for (int i = 0; i < n; i++) begin
          total++;
          if (pop_b[p0+i] !== sent[i]) begin
            bad++; $display("FAIL rand_byte r=%0d i=%0d got=%h exp=%h", r, i, pop_b[p0+i], sent[i]);
          end
        end
      end
      repeat ($urandom_range(0, 5)) step();
    end
  endtask

  initial begin
    reset = 1'b1; dvsr = 11'd0; empty2 = 1'b1; data2 = 8'h00;
    sync_fifo();
    test_reset();
    test_single();
    test_back_to_back();
    test_two_stop();
    test_reset_mid();
    test_empty_stall();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
